// File: rtl/nvdla_car_pkg.sv
// Shared definitions for the core clock/reset (CAR) logic: sequencer state
// encoding and a counter-width helper.
package nvdla_car_pkg;

    typedef enum logic [1:0] {
        SEQ_ASSERT  = 2'd0,
        SEQ_HOLD    = 2'd1,
        SEQ_RELEASE = 2'd2,
        SEQ_RUN     = 2'd3
    } seq_state_e;

    // Width able to count 0..max(a,b)-1, never narrower than one bit.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nvdla_rst_sync.sv
// Single-bit reset synchroniser: asynchronous assert, release after DEPTH
// clock edges.
module nvdla_rst_sync #(
    parameter int DEPTH = 3
) (
    input  logic clk_i,
    input  logic rstn_i,
    output logic sync_o
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], 1'b1};
        end
    end

    assign sync_o = sync_q[DEPTH-1];

endmodule

// File: rtl/nvdla_core_reset_seq.sv
// Core reset sequencer: merges masked reset requests, holds all domains low
// for MIN_ASSERT cycles, then releases them one by one GAP cycles apart.
module nvdla_core_reset_seq
    import nvdla_car_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_DOM    = 4,
    parameter int SYNC_DEPTH = 3,
    parameter int MIN_ASSERT = 16,
    parameter int GAP        = 4
) (
    input  logic               nvdla_clk,
    input  logic               synced_dla_rstn,
    input  logic [NUM_SRC-1:0] src_rstn,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               direct_reset_,
    input  logic               test_mode,
    output logic [NUM_DOM-1:0] dom_rstn,
    output logic               rst_done,
    output logic [NUM_SRC-1:0] rst_cause,
    output logic [1:0]         seq_state
);

    localparam int CNT_W = clog2_max(MIN_ASSERT, GAP);
    localparam int IDX_W = clog2_max(NUM_DOM, 1);

    logic [NUM_SRC-1:0] sync_src;
    logic [NUM_SRC-1:0] new_cause;
    logic               all_ok;

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               done_q, done_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        logic src_clr_n;
        assign src_clr_n = src_rstn[i] & synced_dla_rstn;
        nvdla_rst_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
            .clk_i  (nvdla_clk),
            .rstn_i (src_clr_n),
            .sync_o (sync_src[i])
        );
    end

    assign all_ok    = &(sync_src | src_mask);
    assign new_cause = ~sync_src & ~src_mask;

    always_ff @(posedge nvdla_clk or negedge synced_dla_rstn) begin
        if (!synced_dla_rstn) begin
            state_q <= SEQ_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        cause_d = cause_q;

        if (!all_ok) begin
            // Any missing source aborts whatever is in flight, including a
            // release that would otherwise happen on this very edge.
            state_d = SEQ_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
            cause_d = (state_q == SEQ_ASSERT) ? (cause_q | new_cause) : new_cause;
        end else begin
            unique case (state_q)
                SEQ_ASSERT: begin
                    cause_d = cause_q | new_cause;
                    state_d = SEQ_HOLD;
                    cnt_d   = '0;
                end
                SEQ_HOLD: begin
                    if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                        dom_d[0] = 1'b1;
                        cnt_d    = '0;
                        if (NUM_DOM == 1) begin
                            state_d = SEQ_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = SEQ_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SEQ_RELEASE: begin
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        cnt_d = '0;
                        for (int i = 1; i < NUM_DOM; i++) begin
                            if (idx_q == IDX_W'(i)) dom_d[i] = 1'b1;
                        end
                        if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                            state_d = SEQ_RUN;
                            done_d  = 1'b1;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SEQ_RUN: begin
                    state_d = SEQ_RUN;
                end
                default: begin
                    state_d = SEQ_ASSERT;
                end
            endcase
        end
    end

    // Test-mode override sits after the flops; the sequencer keeps running.
    assign dom_rstn  = test_mode ? {NUM_DOM{direct_reset_}} : dom_q;
    assign rst_done  = test_mode ? direct_reset_ : done_q;
    assign rst_cause = cause_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_nvdla_core_reset_seq.sv
// Directed bench for nvdla_core_reset_seq: a vector table for power-up and
// test-mode behaviour, plus hand-written multi-cycle abort/mask sequences.
module tb_nvdla_core_reset_seq;

  logic       clk;
  logic       rstn;
  logic [1:0] src_rstn;
  logic [1:0] src_mask;
  logic       direct_reset_;
  logic       test_mode;
  logic [3:0] dom_rstn;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic [1:0] seq_state;

  logic       rstn2;
  logic [1:0] src2_rstn;
  logic [1:0] src2_mask;
  logic [0:0] dom2_rstn;
  logic       rst2_done;
  logic [1:0] rst2_cause;
  logic [1:0] seq2_state;

  int n_vec;
  int n_err;

  nvdla_core_reset_seq #(
    .NUM_SRC(2), .NUM_DOM(4), .SYNC_DEPTH(3), .MIN_ASSERT(16), .GAP(4)
  ) dut (
    .nvdla_clk       (clk),
    .synced_dla_rstn (rstn),
    .src_rstn        (src_rstn),
    .src_mask        (src_mask),
    .direct_reset_   (direct_reset_),
    .test_mode       (test_mode),
    .dom_rstn        (dom_rstn),
    .rst_done        (rst_done),
    .rst_cause       (rst_cause),
    .seq_state       (seq_state)
  );

  nvdla_core_reset_seq #(
    .NUM_SRC(2), .NUM_DOM(1), .SYNC_DEPTH(3), .MIN_ASSERT(1), .GAP(1)
  ) dut_small (
    .nvdla_clk       (clk),
    .synced_dla_rstn (rstn2),
    .src_rstn        (src2_rstn),
    .src_mask        (src2_mask),
    .direct_reset_   (1'b1),
    .test_mode       (1'b0),
    .dom_rstn        (dom2_rstn),
    .rst_done        (rst2_done),
    .rst_cause       (rst2_cause),
    .seq_state       (seq2_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         ncyc;
    logic [1:0] src;
    logic [1:0] mask;
    logic       tm;
    logic       dr;
    logic [3:0] edom;
    logic       edone;
    logic [1:0] est;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[12];

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [3:0] a_dom, input logic [3:0] e_dom,
                       input logic a_done, input logic e_done,
                       input logic [1:0] a_st, input logic [1:0] e_st,
                       input logic [1:0] a_c, input logic [1:0] e_c);
    n_vec++;
    if (a_dom !== e_dom || a_done !== e_done || a_st !== e_st || a_c !== e_c) begin
      n_err++;
      $display("FAIL %s: got dom=%h done=%b state=%0d cause=%b, want dom=%h done=%b state=%0d cause=%b",
               name, a_dom, a_done, a_st, a_c, e_dom, e_done, e_st, e_c);
    end
  endtask

  task automatic chk(input string name, input logic [3:0] e_dom, input logic e_done,
                     input logic [1:0] e_st, input logic [1:0] e_c);
    check(name, dom_rstn, e_dom, rst_done, e_done, seq_state, e_st, rst_cause, e_c);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Power-up (rstn released just after edge 0), then test-mode mux in RUN.
    // Cause collects 2'b11 while both synchronisers are still low in ASSERT.
    vecs[0]  = '{"pu_edge3_assert",  3, 2'b11, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 2'b11};
    vecs[1]  = '{"pu_edge4_hold",    1, 2'b11, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 2'b11};
    vecs[2]  = '{"pu_edge19_hold",  15, 2'b11, 2'b00, 1'b0, 1'b1, 4'h0, 1'b0, 2'd1, 2'b11};
    vecs[3]  = '{"pu_edge20_dom0",   1, 2'b11, 2'b00, 1'b0, 1'b1, 4'h1, 1'b0, 2'd2, 2'b11};
    vecs[4]  = '{"pu_edge24_dom1",   4, 2'b11, 2'b00, 1'b0, 1'b1, 4'h3, 1'b0, 2'd2, 2'b11};
    vecs[5]  = '{"pu_edge31_dom2",   7, 2'b11, 2'b00, 1'b0, 1'b1, 4'h7, 1'b0, 2'd2, 2'b11};
    vecs[6]  = '{"pu_edge32_done",   1, 2'b11, 2'b00, 1'b0, 1'b1, 4'hF, 1'b1, 2'd3, 2'b11};
    vecs[7]  = '{"run_stays",        5, 2'b11, 2'b00, 1'b0, 1'b1, 4'hF, 1'b1, 2'd3, 2'b11};
    vecs[8]  = '{"tm_direct_low",    0, 2'b11, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 2'b11};
    vecs[9]  = '{"tm_direct_high",   0, 2'b11, 2'b00, 1'b1, 1'b1, 4'hF, 1'b1, 2'd3, 2'b11};
    vecs[10] = '{"tm_direct_low2",   0, 2'b11, 2'b00, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 2'b11};
    vecs[11] = '{"tm_off_run",       1, 2'b11, 2'b00, 1'b0, 1'b1, 4'hF, 1'b1, 2'd3, 2'b11};

    rstn          = 1'b0;
    rstn2         = 1'b0;
    src_rstn      = 2'b11;
    src_mask      = 2'b00;
    src2_rstn     = 2'b11;
    src2_mask     = 2'b00;
    direct_reset_ = 1'b1;
    test_mode     = 1'b0;

    tick(3);
    chk("reset_state", 4'h0, 1'b0, 2'd0, 2'b00);
    check("small_reset_state", {3'b0, dom2_rstn}, 4'h0, rst2_done, 1'b0,
          seq2_state, 2'd0, rst2_cause, 2'b00);

    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      src_rstn      = vecs[i].src;
      src_mask      = vecs[i].mask;
      test_mode     = vecs[i].tm;
      direct_reset_ = vecs[i].dr;
      if (vecs[i].ncyc == 0) #1;
      else tick(vecs[i].ncyc);
      chk(vecs[i].name, vecs[i].edom, vecs[i].edone, vecs[i].est, vecs[i].ec);
    end

    // Test mode overrides even while the sequencer sits in ASSERT.
    src_rstn = 2'b01;
    tick(1);
    test_mode     = 1'b1;
    direct_reset_ = 1'b1;
    #1;
    chk("tm_in_assert", 4'hF, 1'b1, 2'd0, 2'b10);
    test_mode = 1'b0;
    src_rstn  = 2'b11;
    tick(3);
    tick(1);
    chk("tm_recover_hold", 4'h0, 1'b0, 2'd1, 2'b10);
    tick(28);
    chk("tm_recover_run", 4'hF, 1'b1, 2'd3, 2'b10);

    // Sub-cycle glitch on source 1 while running.
    src_rstn = 2'b01;
    #2;
    src_rstn = 2'b11;
    tick(1);
    chk("glitch_assert", 4'h0, 1'b0, 2'd0, 2'b10);
    tick(2);
    chk("glitch_still_assert", 4'h0, 1'b0, 2'd0, 2'b10);
    tick(1);
    chk("glitch_hold", 4'h0, 1'b0, 2'd1, 2'b10);
    tick(15);
    chk("glitch_pre_dom0", 4'h0, 1'b0, 2'd1, 2'b10);
    tick(1);
    chk("glitch_dom0", 4'h1, 1'b0, 2'd2, 2'b10);
    tick(12);
    chk("glitch_run", 4'hF, 1'b1, 2'd3, 2'b10);

    // Abort in RELEASE right after dom_rstn[1] rises.
    src_rstn = 2'b01;
    tick(1);
    src_rstn = 2'b11;
    tick(4);
    tick(16);
    tick(4);
    chk("abort_pre_dom1", 4'h3, 1'b0, 2'd2, 2'b10);
    src_rstn = 2'b10;
    tick(1);
    chk("abort_all_low", 4'h0, 1'b0, 2'd0, 2'b01);
    tick(2);
    chk("abort_stays_low", 4'h0, 1'b0, 2'd0, 2'b01);
    src_rstn = 2'b11;
    tick(3);
    chk("abort_wait_sync", 4'h0, 1'b0, 2'd0, 2'b01);
    tick(1);
    chk("abort_hold", 4'h0, 1'b0, 2'd1, 2'b01);
    tick(28);
    chk("abort_run", 4'hF, 1'b1, 2'd3, 2'b01);

    // Mask a source held low, then unmask it.
    src_rstn = 2'b01;
    tick(1);
    chk("mask_assert", 4'h0, 1'b0, 2'd0, 2'b10);
    src_mask = 2'b10;
    tick(1);
    chk("mask_hold", 4'h0, 1'b0, 2'd1, 2'b10);
    tick(16);
    chk("mask_dom0", 4'h1, 1'b0, 2'd2, 2'b10);
    tick(12);
    chk("mask_run", 4'hF, 1'b1, 2'd3, 2'b10);
    src_mask = 2'b00;
    tick(1);
    chk("unmask_assert", 4'h0, 1'b0, 2'd0, 2'b10);
    src_rstn = 2'b11;
    tick(4);
    chk("unmask_hold", 4'h0, 1'b0, 2'd1, 2'b10);
    tick(28);
    chk("unmask_run", 4'hF, 1'b1, 2'd3, 2'b10);

    // NUM_DOM=1, MIN_ASSERT=1, GAP=1: HOLD goes straight to RUN.
    rstn2 = 1'b1;
    tick(3);
    check("small_assert", {3'b0, dom2_rstn}, 4'h0, rst2_done, 1'b0,
          seq2_state, 2'd0, rst2_cause, 2'b11);
    tick(1);
    check("small_hold", {3'b0, dom2_rstn}, 4'h0, rst2_done, 1'b0,
          seq2_state, 2'd1, rst2_cause, 2'b11);
    tick(1);
    check("small_run", {3'b0, dom2_rstn}, 4'h1, rst2_done, 1'b1,
          seq2_state, 2'd3, rst2_cause, 2'b11);

    // Block reset mid-run clears everything, including the cause register.
    rstn = 1'b0;
    #1;
    chk("block_reset", 4'h0, 1'b0, 2'd0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nvdla_core_reset_seq.md
# nvdla_core_reset_seq

Parametrised reset sequencer for the NVDLA core clock domain. It merges NUM_SRC asynchronous reset requests into a single internal reset decision and enforces a minimum assertion width. It then releases NUM_DOM downstream reset domains one at a time, in index order, with a fixed gap between releases. It replaces the fixed two-source, single-output reset combiner at the core CAR level, and adds source masking, cause capture and a done indication.

## Interface
Parameters:
- NUM_SRC, 2, number of asynchronous reset request inputs (≥1)
- NUM_DOM, 4, number of sequenced reset domain outputs (≥1)
- SYNC_DEPTH, 3, synchroniser flop depth per source (≥2)
- MIN_ASSERT, 16, cycles all domains stay low after every source deasserts (≥1)
- GAP, 4, cycles between consecutive domain releases (≥1)

Ports:
- nvdla_clk  in  1  core clock
- synced_dla_rstn  in  1  block reset, asynchronous, active-low (already synchronised)
- src_rstn  in  NUM_SRC  asynchronous active-low reset requests
- src_mask  in  NUM_SRC  quasi-static; 1 = ignore that source
- direct_reset_  in  1  test-mode reset override, active-low
- test_mode  in  1  1 = bypass sequencing
- dom_rstn  out  NUM_DOM  sequenced active-low domain resets
- rst_done  out  1  all domains released
- rst_cause  out  NUM_SRC  unmasked sources that triggered the latest reset episode
- seq_state  out  2  FSM state: 0 ASSERT, 1 HOLD, 2 RELEASE, 3 RUN

## Operation
- Each src_rstn[i] passes through a SYNC_DEPTH synchroniser with asynchronous assert and synchronous deassert. The synchroniser is cleared by (src_rstn[i] & synced_dla_rstn).
- Internal signal all_ok = AND over i of (sync_src[i] | src_mask[i]).
- FSM states:
  - ASSERT: all dom_rstn = 0. Move to HOLD when all_ok = 1.
  - HOLD: counter runs 0..MIN_ASSERT-1. On the terminal count, set dom_rstn[0] = 1. If NUM_DOM = 1, go to RUN; otherwise go to RELEASE with idx = 1 and the counter cleared.
  - RELEASE: counter runs 0..GAP-1. On the terminal count, set dom_rstn[idx] = 1 and increment idx. When idx = NUM_DOM-1 is released, go to RUN.
  - RUN: rst_done = 1. Remain here while all_ok = 1.
- all_ok = 0 in any state sends the FSM to ASSERT on the next edge. All dom_rstn and rst_done are cleared on that same edge, the counter and idx are cleared, and any in-progress HOLD or RELEASE is aborted.
- rst_cause:
  - On the edge entering ASSERT from another state, it loads ~sync_src & ~src_mask.
  - While in ASSERT, it ORs in new ~sync_src & ~src_mask each cycle.
  - It holds its value otherwise.
  - After a synced_dla_rstn reset it reads 0.
- Masking a source while it is low raises all_ok, and sequencing proceeds. Unmasking a source that is low forces ASSERT.
- test_mode = 1:
  - dom_rstn = {NUM_DOM{direct_reset_}} and rst_done = direct_reset_, both combinational muxes after the flops.
  - The FSM, rst_cause and seq_state continue to run unchanged.
- Counter width: $clog2(max(MIN_ASSERT, GAP)). The counter never wraps; it is cleared on each terminal count and on each state change.

## Timing
- Reset values on synced_dla_rstn = 0: dom_rstn = 0, rst_done = 0, rst_cause = 0, seq_state = ASSERT, counter = 0, idx = 0, synchronisers = 0.
- Deassertion latency:
  - The last required source rises → sync output rises after SYNC_DEPTH edges → HOLD at +1 edge.
  - dom_rstn[0] rises MIN_ASSERT edges after HOLD entry.
  - dom_rstn[k] rises k·GAP edges after dom_rstn[0].
  - rst_done rises on the same edge as dom_rstn[NUM_DOM-1].
- Assertion latency: a source falls → its sync output falls asynchronously → all dom_rstn fall at the next nvdla_clk edge.
- A source glitch shorter than one cycle still causes a full ASSERT episode.
- If all_ok drops on a terminal-count edge, ASSERT wins and no release occurs.

## Structure
- Shared package nvdla_car_pkg holds the state encoding constants (SEQ_ASSERT, SEQ_HOLD, SEQ_RELEASE, SEQ_RUN) and a clog2/max helper.
- Sub-module nvdla_rst_sync (DEPTH parameter) provides a single-bit asynchronous-assert, synchronous-release synchroniser. It is instantiated NUM_SRC times via generate.
- The FSM, counter, idx, cause register and test-mode muxes live in the top module.

## Test plan
- Defaults: deassert synced_dla_rstn with both src_rstn high at cycle 0. Required: HOLD at edge 4, dom_rstn[0] high at edge 20, dom_rstn[3] and rst_done high at edge 32, seq_state = 3.
- In RUN, pulse src_rstn[1] low for 2 ns. Required: all dom_rstn = 0 at the next edge, rst_cause = 2'b10, then a full re-sequence (dom_rstn[0] at +4+16 edges after the pulse ends).
- In RELEASE after dom_rstn[1] rises, drop src_rstn[0]. Required: all outputs 0 at the next edge, rst_cause = 2'b01, no partial release remaining.
- Hold src_rstn[1] low, then set src_mask = 2'b10. Required: sequencing completes with dom_rstn = 4'hF; clearing the mask returns the FSM to ASSERT.
- test_mode = 1 with direct_reset_ toggling 0→1→0. Required: dom_rstn follows 0→F→0 and rst_done follows 0→1→0 combinationally, independent of the FSM state.
- NUM_DOM = 1, MIN_ASSERT = 1, GAP = 1. Required: HOLD→RUN directly, with dom_rstn and rst_done rising 1 edge after HOLD entry.
